// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, 2-flop row synchroniser, debounce, single-key encode.
// Define KEYPAD_REPEAT_EN to add an auto-repeat gap on keypad_pressed while a key is held.
module keypad_scanner #(
  parameter int SCAN_DIV     = 27000,
  parameter int SETTLE_CYC   = 8,
  parameter int DEBOUNCE_CYC = 270000,
  parameter int REPEAT_CYC   = 13500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       keypad_pressed,
  output logic [4:0] key
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] SETTLE_V  = DW'(SETTLE_CYC);
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST  = BW'(DEBOUNCE_CYC - 1);

  generate
    if (SETTLE_CYC >= SCAN_DIV || DEBOUNCE_CYC < 1 || REPEAT_CYC < 2) begin : g_bad_param
      $error("keypad_scanner: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      sync1_q, sync2_q;
  logic [1:0]      col_q, col_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   deb_q, deb_d;
  logic [3:0]      cand_q, cand_d;
  logic [4:0]      key_q, key_d;
  logic            pressed_q, pressed_d;
  logic [3:0]      rows, cand_pat;
  logic            row_ok, idle;
  logic [1:0]      row_idx;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  assign rows           = sync2_q;
  assign idle           = (rows == 4'hF);
  assign cand_pat       = ~(4'b0001 << cand_q[3:2]);
  assign col_out        = ~(4'b0001 << col_q);
  assign keypad_pressed = pressed_q;
  assign key            = key_q;

  always_comb begin
    row_ok  = 1'b1;
    row_idx = 2'd0;
    case (rows)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    deb_d     = deb_q;
    cand_d    = cand_q;
    key_d     = key_q;
    pressed_d = pressed_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = rep_q;
`endif
    case (state_q)
      SCAN: begin
        if (dwell_q == SETTLE_V && row_ok) begin
          cand_d  = {row_idx, col_q};
          deb_d   = '0;
          dwell_d = '0;
          state_d = DEBOUNCE;
        end else if (dwell_q == DWELL_MAX) begin
          dwell_d = '0;
          col_d   = col_q + 2'd1;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (rows == cand_pat) begin
          if (deb_q == DEB_LAST) begin
            state_d   = HELD;
            pressed_d = 1'b1;
            key_d     = {1'b0, cand_q};
`ifdef KEYPAD_REPEAT_EN
            rep_d     = '0;
`endif
          end else begin
            deb_d = deb_q + BW'(1);
          end
        end else begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end
      end
      HELD: begin
        if (rows != cand_pat) begin
          // The idle cycle that exposes the release is the first of the debounce window.
          state_d   = RELEASE;
          deb_d     = idle ? BW'(1) : '0;
          pressed_d = 1'b1;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          if (rep_q == REP_LAST) begin
            rep_d     = '0;
            pressed_d = 1'b0;
          end else begin
            rep_d     = rep_q + RW'(1);
            pressed_d = 1'b1;
          end
`endif
        end
      end
      RELEASE: begin
        if (idle) begin
          if (deb_q >= DEB_LAST) begin
            state_d   = SCAN;
            pressed_d = 1'b0;
            col_d     = col_q + 2'd1;
            dwell_d   = '0;
            deb_d     = '0;
          end else begin
            deb_d = deb_q + BW'(1);
          end
        end else if (rows == cand_pat) begin
          state_d = HELD;
          deb_d   = '0;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          deb_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      state_q   <= SCAN;
      col_q     <= 2'd0;
      dwell_q   <= '0;
      deb_q     <= '0;
      cand_q    <= 4'd0;
      key_q     <= 5'd31;
      pressed_q <= 1'b0;
    end else begin
      sync1_q   <= row_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      deb_q     <= deb_d;
      cand_q    <= cand_d;
      key_q     <= key_d;
      pressed_q <= pressed_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

endmodule
